// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data-memory handshake: a word array
// serving LW/LBU/SW/SB with a fixed, parameterised response latency.
module data_mem_responder #(
    parameter int ADDR_WIDTH_P = 12,
    parameter int LATENCY_P    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [35:0]             mem_in_i,
    input  logic [ADDR_WIDTH_P-1:0] addr_i,
    output logic [33:0]             mem_out_o,
    output logic                    misalign_o
);

    localparam int WORDS_P = 1 << (ADDR_WIDTH_P - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_r;
    state_e                  state_next_s;
    logic [3:0]              cnt_r;
    logic [31:0]             resp_data_r;
    logic                    misalign_r;
    logic [31:0]             mem_r [WORDS_P];

    logic [31:0]             wdata_s;
    logic                    in_valid_s;
    logic                    wen_s;
    logic                    bnw_s;
    logic                    core_yumi_s;
    logic [ADDR_WIDTH_P-3:0] index_s;
    logic [1:0]              lane_s;
    logic [31:0]             rd_word_s;
    logic                    accept_s;

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    assign wdata_s     = mem_in_i[35:4];
    assign in_valid_s  = mem_in_i[3];
    assign wen_s       = mem_in_i[2];
    assign bnw_s       = mem_in_i[1];
    assign core_yumi_s = mem_in_i[0];
    assign index_s     = addr_i[ADDR_WIDTH_P-1:2];
    assign lane_s      = addr_i[1:0];
    assign rd_word_s   = mem_r[index_s];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (LATENCY_P == 1) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (core_yumi_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic; reset suppresses acceptance in the same cycle
    always_comb begin
        accept_s  = 1'b0;
        mem_out_o = 34'd0;
        if ((state_r == IDLE) && in_valid_s && !reset) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        mem_out_o = {resp_data_r, (state_r == RESP), accept_s};
    end

    // Latency counter: loaded at acceptance, counts down while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (accept_s && (LATENCY_P > 1)) begin
            cnt_r <= 4'(LATENCY_P - 2);
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response data captured at acceptance so later writes cannot disturb it
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data_r <= 32'd0;
        end else if (accept_s) begin
            if (wen_s) begin
                resp_data_r <= 32'd0;
            end else if (bnw_s) begin
                resp_data_r <= {24'd0, select_byte(rd_word_s, lane_s)};
            end else begin
                resp_data_r <= rd_word_s;
            end
        end else begin
            resp_data_r <= resp_data_r;
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (accept_s && wen_s) begin
            if (bnw_s) begin
                mem_r[index_s][{lane_s, 3'b000} +: 8] <= wdata_s[7:0];
            end else begin
                mem_r[index_s] <= wdata_s;
            end
        end
    end

    // Sticky misalignment flag for word accesses
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else if (accept_s && !bnw_s && (lane_s != 2'd0)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign misalign_o = misalign_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: two instances (latency 2 and 1)
// driven by directed and random transactions against an array-based model.
module tb_data_mem_responder;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0][31:0] wd;
    logic [1:0]       v, we, bn, cy;
    logic [1:0][11:0] ad;
    logic [1:0][35:0] mi;
    logic [1:0][33:0] mo;
    logic [1:0]       mis;

    logic [31:0] ref_mem [2][1024];
    logic [1:0]  exp_mis;
    int          lat_exp [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mi[0] = {wd[0], v[0], we[0], bn[0], cy[0]};
    assign mi[1] = {wd[1], v[1], we[1], bn[1], cy[1]};

    data_mem_responder #(.ADDR_WIDTH_P(12), .LATENCY_P(2)) dut_l2 (
        .clk(clk), .reset(reset), .mem_in_i(mi[0]), .addr_i(ad[0]),
        .mem_out_o(mo[0]), .misalign_o(mis[0])
    );

    data_mem_responder #(.ADDR_WIDTH_P(12), .LATENCY_P(1)) dut_l1 (
        .clk(clk), .reset(reset), .mem_in_i(mi[1]), .addr_i(ad[1]),
        .mem_out_o(mo[1]), .misalign_o(mis[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request/response exchange on instance w, checked against the model.
    task automatic txn(input int w, input logic wen, input logic bnw, input logic [31:0] d,
                       input logic [11:0] a, input int hold, output logic [31:0] rd);
        logic [31:0] exp;
        int idx, ln, lat;
        idx = int'(a[11:2]);
        ln  = int'(a[1:0]);
        if (wen) begin
            exp = 32'd0;
            if (bnw) ref_mem[w][idx][ln*8 +: 8] = d[7:0];
            else     ref_mem[w][idx] = d;
        end else if (bnw) begin
            exp = {24'd0, ref_mem[w][idx][ln*8 +: 8]};
        end else begin
            exp = ref_mem[w][idx];
        end
        if (!bnw && ln != 0) exp_mis[w] = 1'b1;

        wd[w] = d; we[w] = wen; bn[w] = bnw; ad[w] = a; v[w] = 1'b1; cy[w] = 1'b0;
        #1;
        chk("req_yumi", {31'd0, mo[w][0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v[w] = 1'b0;
        lat = 1;
        while (mo[w][1] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_exp[w]));
        chk("read_data", mo[w][33:2], exp);
        rd = mo[w][33:2];
        chk("resp_yumi", {31'd0, mo[w][0]}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            v[w] = 1'b1; we[w] = 1'b0; bn[w] = 1'b0; ad[w] = 12'h004;
            #1;
            chk("hold_yumi", {31'd0, mo[w][0]}, 32'd0);
            @(negedge clk);
            chk("hold_valid", {31'd0, mo[w][1]}, 32'd1);
            chk("hold_data", mo[w][33:2], exp);
        end
        v[w] = 1'b0; cy[w] = 1'b1;
        @(negedge clk);
        cy[w] = 1'b0;
        chk("consumed_valid", {31'd0, mo[w][1]}, 32'd0);
        chk("misalign", {31'd0, mis[w]}, {31'd0, exp_mis[w]});
    endtask

    initial begin
        logic [31:0] rd;
        lat_exp[0] = 2;
        lat_exp[1] = 1;
        exp_mis = 2'b00;
        reset = 1'b1;
        wd = '0; v = 2'b00; we = 2'b00; bn = 2'b00; cy = 2'b00; ad = '0;

        // Reset wins over a simultaneous request
        @(negedge clk);
        v[0] = 1'b1; ad[0] = 12'h010;
        #1;
        chk("reset_yumi", {31'd0, mo[0][0]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        v[0] = 1'b0; reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk("reset_data", mo[w][33:2], 32'd0);
            chk("reset_flags", {30'd0, mo[w][1:0]}, 32'd0);
            chk("reset_misalign", {31'd0, mis[w]}, 32'd0);
        end

        // Word write then read
        txn(0, 1'b1, 1'b0, 32'hDEADBEEF, 12'h010, 0, rd);
        chk("sw_resp_zero", rd, 32'd0);
        txn(0, 1'b0, 1'b0, 32'd0, 12'h010, 0, rd);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        // Byte write merges into one lane
        txn(0, 1'b1, 1'b0, 32'h11223344, 12'h010, 0, rd);
        txn(0, 1'b1, 1'b1, 32'h000000A5, 12'h013, 0, rd);
        txn(0, 1'b0, 1'b0, 32'd0, 12'h010, 0, rd);
        chk("sb_merge", rd, 32'hA5223344);
        txn(0, 1'b0, 1'b1, 32'd0, 12'h013, 0, rd);
        chk("lbu", rd, 32'h000000A5);

        // Back-pressure: response held for 5 cycles
        txn(0, 1'b0, 1'b0, 32'd0, 12'h010, 5, rd);

        // Misaligned word read uses the aligned word and sets the flag
        txn(0, 1'b0, 1'b0, 32'd0, 12'h012, 0, rd);
        chk("misaligned_lw", rd, 32'hA5223344);
        chk("misalign_set", {31'd0, mis[0]}, 32'd1);
        txn(0, 1'b0, 1'b0, 32'd0, 12'h010, 0, rd);
        chk("misalign_sticky", {31'd0, mis[0]}, 32'd1);

        // Random traffic over the low 16 words of both instances
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) txn(w, 1'b1, 1'b0, $urandom, 12'(i * 4), 0, rd);
            for (int i = 0; i < 30; i++) begin
                txn(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    12'($urandom_range(0, 63)), $urandom_range(0, 2), rd);
            end
        end

        // Latency 1, bottom and top words back to back
        txn(1, 1'b1, 1'b0, 32'h0BADF00D, 12'h000, 0, rd);
        txn(1, 1'b1, 1'b0, 32'h7E57C0DE, 12'hFFC, 0, rd);
        txn(1, 1'b0, 1'b0, 32'd0, 12'h000, 0, rd);
        chk("l1_bottom", rd, 32'h0BADF00D);
        txn(1, 1'b0, 1'b0, 32'd0, 12'hFFC, 0, rd);
        chk("l1_top", rd, 32'h7E57C0DE);

        // Reset while a write's response is pending: write persists, response dropped
        wd[0] = 32'hCAFEF00D; we[0] = 1'b1; bn[0] = 1'b0; ad[0] = 12'h020; v[0] = 1'b1;
        ref_mem[0][8] = 32'hCAFEF00D;
        #1;
        chk("wait_req_yumi", {31'd0, mo[0][0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        v[0] = 1'b0; we[0] = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_mis = 2'b00;
        chk("dropped_valid", {31'd0, mo[0][1]}, 32'd0);
        chk("reset_clears_misalign", {31'd0, mis[0]}, 32'd0);
        txn(0, 1'b0, 1'b0, 32'd0, 12'h020, 0, rd);
        chk("write_persists", rd, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
